ship_rom_arb: RTL and testbench



---
 rtl/ship_rom_arb.sv | 90 +++++++++
 tb/tb_ship_rom_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ship_rom_arb.sv
// ship_rom_arb: round-robin arbiter sharing one registered sprite line ROM between requesters.
// Ports: clk, rst_n (async active-low); req/req_addr requests with packed addresses;
// gnt one-hot combinational grant; rom_addr/rom_data ROM side; rsp_valid/rsp_id/rsp_data
// registered response returned ROM_LAT+1 edges after the grant edge.
// Build option: SHIP_ROM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, no ptr).
module ship_rom_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 48,
  parameter int ROM_LAT = 1,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [IW-1:0]             rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);
  // Stage 0 runs alongside rom_addr; stage ROM_LAT lines up with rom_data.
  logic [NUM_REQ-1:0] tag_pipe [0:ROM_LAT];
  logic [ADDR_W-1:0]  addr_sel;
  logic [IW-1:0]      tag_id;
`ifdef SHIP_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    gnt = rst_n ? gnt : '0;
  end
`else
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          found;
  // Two passes emulate a search starting at ptr+1 and wrapping to 0..ptr.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && i > int'(ptr) && req[i]) begin
        gnt[i] = 1'b1;
        win    = i[IW-1:0];
        found  = 1'b1;
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && i <= int'(ptr) && req[i]) begin
        gnt[i] = 1'b1;
        win    = i[IW-1:0];
        found  = 1'b1;
      end
    gnt = rst_n ? gnt : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= IW'(NUM_REQ - 1);
    else if (|gnt) ptr <= win;
`endif
  always_comb begin
    addr_sel = '0;
    tag_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*ADDR_W +: ADDR_W];
      if (tag_pipe[ROM_LAT][i]) tag_id = tag_id | i[IW-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rom_addr  <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (|gnt) rom_addr <= addr_sel;
      tag_pipe[0] <= gnt;
      for (int k = 1; k <= ROM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      rsp_valid <= tag_pipe[ROM_LAT];
      if (|tag_pipe[ROM_LAT]) begin
        rsp_data <= rom_data;
        rsp_id   <= tag_id;
      end
    end
endmodule

// File: tb/tb_ship_rom_arb.sv
// tb_ship_rom_arb: directed bench for ship_rom_arb with a one-stage registered ROM model.
module tb_ship_rom_arb;
`ifdef SHIP_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [15:0] req_addr = '0;
  logic [1:0]  gnt;
  logic [7:0]  rom_addr;
  logic [47:0] rom_data;
  logic [1:0]  rsp_valid;
  logic [0:0]  rsp_id;
  logic [47:0] rsp_data;
  logic [47:0] ones = {48{1'b1}};
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  // Sprite ROM stand-in: lines below 8'h30 are solid, the rest empty.
  always_ff @(posedge clk) rom_data <= (rom_addr < 8'h30) ? {48{1'b1}} : 48'h0;

  ship_rom_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    req = 2'b11;
    rst_n = 1'b0;
    tick();
    #1;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    vec++; if (rom_addr !== 8'h00) begin errs++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    vec++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    vec++; if (rsp_data !== 48'h0) begin errs++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    req = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    apply_reset();
    req = 2'b01;
    req_addr[7:0] = 8'h10;
    #1;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    tick();
    req = 2'b00;
    vec++; if (rom_addr !== 8'h10) begin errs++; $display("FAIL single_rom_addr got=%h exp=10", rom_addr); end
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL single_early_valid got=%b exp=00", rsp_valid); end
    tick();
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL single_early_valid2 got=%b exp=00", rsp_valid); end
    tick();
    vec++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    vec++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL single_rsp_id got=%b exp=0", rsp_id); end
    vec++; if (rsp_data !== ones) begin errs++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, ones); end
    tick();
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL single_valid_drop got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_alternate;
    logic [1:0]  eg, ev;
    logic [0:0]  ei;
    logic [47:0] ed;
    int j;
    apply_reset();
    req_addr = {8'h50, 8'h00};
    for (int k = 0; k < 8; k++) begin
      req = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) begin
        eg = (FIXED || k % 2 == 0) ? 2'b01 : 2'b10;
        vec++; if (gnt !== eg) begin errs++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", k, gnt, eg); end
      end
      j = k - 3;
      ev = 2'b00;
      ei = 1'b0;
      ed = ones;
      if (j >= 0 && j < 4) begin
        ev = (FIXED || j % 2 == 0) ? 2'b01 : 2'b10;
        ei = ev[1];
        ed = ev[1] ? 48'h0 : ones;
      end
      vec++; if (rsp_valid !== ev) begin errs++; $display("FAIL alt_valid[%0d] got=%b exp=%b", k, rsp_valid, ev); end
      if (ev != 2'b00) begin
        vec++; if (rsp_id !== ei) begin errs++; $display("FAIL alt_id[%0d] got=%b exp=%b", k, rsp_id, ei); end
        vec++; if (rsp_data !== ed) begin errs++; $display("FAIL alt_data[%0d] got=%h exp=%h", k, rsp_data, ed); end
      end
      tick();
    end
  endtask

  task automatic test_drop_req0;
    apply_reset();
    req = 2'b11;
    #1;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL drop_gnt0 got=%b exp=01", gnt); end
    tick();
    req = 2'b10;
    #1;
    vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL drop_gnt1 got=%b exp=10", gnt); end
    tick();
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ea;
    logic [47:0] ed;
    int j;
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      req = (k < 8) ? 2'b10 : 2'b00;
      req_addr[15:8] = 8'h2e + 8'(k);
      #1;
      if (k < 8) begin
        vec++; if (gnt !== 2'b10) begin errs++; $display("FAIL b2b_gnt[%0d] got=%b exp=10", k, gnt); end
      end
      if (k >= 1 && k <= 8) begin
        ea = 8'h2e + 8'(k - 1);
        vec++; if (rom_addr !== ea) begin errs++; $display("FAIL b2b_rom_addr[%0d] got=%h exp=%h", k, rom_addr, ea); end
      end
      j = k - 3;
      if (j >= 0) begin
        ed = (8'h2e + 8'(j) < 8'h30) ? ones : 48'h0;
        vec++; if (rsp_valid !== 2'b10) begin errs++; $display("FAIL b2b_valid[%0d] got=%b exp=10", k, rsp_valid); end
        vec++; if (rsp_id !== 1'b1) begin errs++; $display("FAIL b2b_id[%0d] got=%b exp=1", k, rsp_id); end
        vec++; if (rsp_data !== ed) begin errs++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, rsp_data, ed); end
      end
      tick();
    end
    tick();
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL b2b_tail got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req = 2'b01;
    req_addr[7:0] = 8'h20;
    tick();
    req = 2'b11;
    rst_n = 1'b0;
    #1;
    vec++; if (gnt !== 2'b00) begin errs++; $display("FAIL mid_gnt got=%b exp=00", gnt); end
    vec++; if (rom_addr !== 8'h00) begin errs++; $display("FAIL mid_rom_addr got=%h exp=00", rom_addr); end
    vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL mid_rsp_valid got=%b exp=00", rsp_valid); end
    vec++; if (rsp_data !== 48'h0) begin errs++; $display("FAIL mid_rsp_data got=%h exp=0", rsp_data); end
    tick();
    req = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL mid_stale_valid[%0d] got=%b exp=00", k, rsp_valid); end
    end
    req = 2'b11;
    #1;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL mid_first_gnt got=%b exp=01", gnt); end
    tick();
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_glitch;
    apply_reset();
    req = 2'b01;
    req_addr = {8'h40, 8'h05};
    #1;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL glitch_gnt0 got=%b exp=01", gnt); end
    tick();
    // req[1] appears and vanishes before the edge that would have granted it
    req = 2'b11;
    #1;
    vec++; if (gnt !== (FIXED ? 2'b01 : 2'b10)) begin errs++; $display("FAIL glitch_comb_gnt got=%b exp=%b", gnt, FIXED ? 2'b01 : 2'b10); end
    #1;
    req = 2'b01;
    #1;
    vec++; if (gnt !== 2'b01) begin errs++; $display("FAIL glitch_gnt_after_drop got=%b exp=01", gnt); end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) begin
        vec++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL glitch_valid[%0d] got=%b exp=01", k, rsp_valid); end
        vec++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL glitch_id[%0d] got=%b exp=0", k, rsp_id); end
      end
    end
    req = 2'b11;
    #1;
    vec++; if (gnt !== (FIXED ? 2'b01 : 2'b10)) begin errs++; $display("FAIL glitch_ptr_gnt got=%b exp=%b", gnt, FIXED ? 2'b01 : 2'b10); end
    tick();
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_drop_req0();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
